// File: rtl/down_cnt_ld.sv
// Loadable down-counter with an IDLE/RUN state machine and a one-cycle DONE pulse.
// With TMR=1 every register is held in three copies, and each copy reloads from the majority vote.
module down_cnt_ld #(
  parameter int Width = 4,
  parameter int TMR   = 0
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             LOAD,
  input  logic [Width-1:0] D,
  input  logic             CE,
  output logic [Width-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NCopy = (TMR != 0) ? 3 : 1;

  // Voted (or single-copy) view of the registers; all next-state logic reads these.
  state_e           state_v;
  logic [Width-1:0] cnt_v;
  logic             done_v;

  state_e           state_d;
  logic [Width-1:0] cnt_d;
  logic             done_d;

  function automatic logic [Width-1:0] vote_w(input logic [Width-1:0] a,
                                              input logic [Width-1:0] b,
                                              input logic [Width-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic vote_1(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    state_d = state_v;
    cnt_d   = cnt_v;
    done_d  = 1'b0;
    if (LOAD) begin
      cnt_d   = D;
      state_d = (D != '0) ? RUN : IDLE;
    end else if (state_v == RUN && CE) begin
      cnt_d = cnt_v - Width'(1);
      if (cnt_v == Width'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCopy; i++) begin : g_copy
    // Copies are identical by construction; keep stops synthesis from merging them.
    (* keep = "true" *) state_e           state_q;
    (* keep = "true" *) logic [Width-1:0] cnt_q;
    (* keep = "true" *) logic             done_q;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
      end
    end
  end

  if (NCopy == 3) begin : g_vote
    assign cnt_v   = vote_w(g_copy[0].cnt_q, g_copy[1].cnt_q, g_copy[2].cnt_q);
    assign state_v = state_e'(vote_1(g_copy[0].state_q, g_copy[1].state_q, g_copy[2].state_q));
    assign done_v  = vote_1(g_copy[0].done_q, g_copy[1].done_q, g_copy[2].done_q);
  end else begin : g_single
    assign cnt_v   = g_copy[0].cnt_q;
    assign state_v = g_copy[0].state_q;
    assign done_v  = g_copy[0].done_q;
  end

  assign Q    = cnt_v;
  assign BUSY = (state_v == RUN);
  assign DONE = done_v;

endmodule

// File: tb/tb_down_cnt_ld.sv
// Directed bench: a single-copy and a triplicated counter run side by side on identical stimulus,
// both checked against hand-computed {Q, BUSY, DONE} values; single-copy upsets are injected into the TMR copy.
module tb_down_cnt_ld;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] d;
  logic         ce;

  logic [W-1:0] q0, q1;
  logic         busy0, busy1, done0, done1;
  logic [W+1:0] obs0, obs1;

  int n_pass  = 0;
  int n_total = 0;

  down_cnt_ld #(.Width(W), .TMR(0)) dut0 (
    .CLK(clk), .RSTN(rst_n), .LOAD(load), .D(d), .CE(ce),
    .Q(q0), .BUSY(busy0), .DONE(done0)
  );

  down_cnt_ld #(.Width(W), .TMR(1)) dut1 (
    .CLK(clk), .RSTN(rst_n), .LOAD(load), .D(d), .CE(ce),
    .Q(q1), .BUSY(busy1), .DONE(done1)
  );

  assign obs0 = {q0, busy0, done0};
  assign obs1 = {q1, busy1, done1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; d = '0; ce = 1'b1;
    step();
    step();
    n_total++;
    if (obs0 !== 6'b0 || obs1 !== 6'b0)
      $display("FAIL reset: tmr0={q,busy,done}=%b tmr1=%b expected %b", obs0, obs1, 6'b0);
    else n_pass++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_count_down();
    logic [W+1:0] exp [6] = '{{4'd3, 1'b1, 1'b0}, {4'd2, 1'b1, 1'b0}, {4'd1, 1'b1, 1'b0},
                              {4'd0, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b0}, {4'd0, 1'b0, 1'b0}};
    load = 1'b1; d = 4'd3; ce = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (obs0 !== exp[i] || obs1 !== exp[i])
        $display("FAIL count_down[%0d]: tmr0=%b tmr1=%b expected %b", i, obs0, obs1, exp[i]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_ce_toggle();
    logic         ce_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] q_seq  [4] = '{4'd14, 4'd14, 4'd13, 4'd13};
    load = 1'b1; d = 4'd15; ce = 1'b0;
    step();
    load = 1'b0;
    n_total++;
    if (obs0 !== {4'd15, 1'b1, 1'b0} || obs1 !== {4'd15, 1'b1, 1'b0})
      $display("FAIL ce_toggle_load: tmr0=%b tmr1=%b expected %b", obs0, obs1, {4'd15, 1'b1, 1'b0});
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ce = ce_seq[i];
      step();
      n_total++;
      if (obs0 !== {q_seq[i], 1'b1, 1'b0} || obs1 !== {q_seq[i], 1'b1, 1'b0})
        $display("FAIL ce_toggle[%0d]: tmr0=%b tmr1=%b expected %b", i, obs0, obs1, {q_seq[i], 1'b1, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_reload();
    logic [W+1:0] exp [5] = '{{4'd3, 1'b1, 1'b0}, {4'd2, 1'b1, 1'b0}, {4'd1, 1'b1, 1'b0},
                              {4'd0, 1'b0, 1'b1}, {4'd0, 1'b0, 1'b0}};
    load = 1'b1; d = 4'd5; ce = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (obs0 !== exp[i] || obs1 !== exp[i])
        $display("FAIL reload[%0d]: tmr0=%b tmr1=%b expected %b", i, obs0, obs1, exp[i]);
      else n_pass++;
      if (i == 0) begin
        load = 1'b1; d = 4'd2;
      end else begin
        load = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_zero_and_idle();
    load = 1'b1; d = 4'd0; ce = 1'b0;
    step();
    n_total++;
    if (obs0 !== 6'b0 || obs1 !== 6'b0)
      $display("FAIL load_zero: tmr0=%b tmr1=%b expected %b", obs0, obs1, 6'b0);
    else n_pass++;
    d = 4'd3;
    step();
    d = 4'd0;
    step();
    n_total++;
    if (obs0 !== 6'b0 || obs1 !== 6'b0)
      $display("FAIL load_zero_from_run: tmr0=%b tmr1=%b expected %b", obs0, obs1, 6'b0);
    else n_pass++;
    load = 1'b0; ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if (obs0 !== 6'b0 || obs1 !== 6'b0)
        $display("FAIL idle_ce[%0d]: tmr0=%b tmr1=%b expected %b", i, obs0, obs1, 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_max_value();
    logic [W+1:0] exp;
    load = 1'b1; d = 4'd15; ce = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      exp = {4'(k < 16 ? 15 - k : 0), k < 15, k == 15};
      n_total++;
      if (obs0 !== exp || obs1 !== exp)
        $display("FAIL max_value[%0d]: tmr0=%b tmr1=%b expected %b", k, obs0, obs1, exp);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    load = 1'b1; d = 4'd6; ce = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    n_total++;
    if (obs0 !== {4'd4, 1'b1, 1'b0} || obs1 !== {4'd4, 1'b1, 1'b0})
      $display("FAIL reset_mid_pre: tmr0=%b tmr1=%b expected %b", obs0, obs1, {4'd4, 1'b1, 1'b0});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (obs0 !== 6'b0 || obs1 !== 6'b0)
      $display("FAIL reset_mid_async: tmr0=%b tmr1=%b expected %b", obs0, obs1, 6'b0);
    else n_pass++;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (obs0 !== 6'b0 || obs1 !== 6'b0)
        $display("FAIL reset_mid_after[%0d]: tmr0=%b tmr1=%b expected %b", i, obs0, obs1, 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_tmr_upset();
    load = 1'b1; d = 4'd9; ce = 1'b1;
    step();
    load = 1'b0;
    step();
    #1 force dut1.g_copy[1].cnt_q = 4'd3;
    force dut1.g_copy[0].done_q = 1'b1;
    #1;
    n_total++;
    if (dut1.g_copy[1].cnt_q !== 4'd3 || obs1 !== {4'd8, 1'b1, 1'b0})
      $display("FAIL upset_masked: copy1=%0d tmr1=%b expected copy1=3 out=%b",
               dut1.g_copy[1].cnt_q, obs1, {4'd8, 1'b1, 1'b0});
    else n_pass++;
    release dut1.g_copy[1].cnt_q;
    release dut1.g_copy[0].done_q;
    step();
    n_total++;
    if (dut1.g_copy[0].cnt_q !== 4'd7 || dut1.g_copy[1].cnt_q !== 4'd7 || dut1.g_copy[2].cnt_q !== 4'd7 ||
        dut1.g_copy[0].done_q !== 1'b0)
      $display("FAIL upset_scrub: copies=%0d,%0d,%0d done0=%b expected 7,7,7 done0=0",
               dut1.g_copy[0].cnt_q, dut1.g_copy[1].cnt_q, dut1.g_copy[2].cnt_q, dut1.g_copy[0].done_q);
    else n_pass++;
    n_total++;
    if (obs0 !== {4'd7, 1'b1, 1'b0} || obs1 !== {4'd7, 1'b1, 1'b0})
      $display("FAIL upset_next: tmr0=%b tmr1=%b expected %b", obs0, obs1, {4'd7, 1'b1, 1'b0});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_ce_toggle();
    test_reload();
    test_zero_and_idle();
    test_max_value();
    test_reset_mid();
    test_tmr_upset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
